// File: rtl/out_xor_reduce.sv
// out_xor_reduce: output-compaction stage that sits between an HLS kernel's output streams and
// the board pins.
//
// Operation:
//   - NUM_CH write-strobed streams are folded through a 3-stage pipeline into a single
//     OUT_WIDTH-bit XOR word.
//   - When the macro OUT_XOR_REDUCE_SIG_EN is defined, the block also computes a per-run
//     signature. The signature is a rotating-XOR accumulator plus a saturating beat counter,
//     framed by ap_start/ap_done and reported once per run.
//
// Parameters:
//   NUM_CH     number of kernel output streams (1..16)
//   DIN_WIDTH  width of each stream word; must be a multiple of OUT_WIDTH
//   OUT_WIDTH  width of the folded word
//   SIG_WIDTH  signature width; must be >= OUT_WIDTH
//   CNT_WIDTH  beat-counter width
//
// Ports:
//   ap_clk, ap_rst_n  kernel clock; asynchronous active-low reset
//   ap_start          kernel start level
//   ap_done           kernel done pulse (1 cycle)
//   ch_din            stream words; channel k occupies [k*DIN_WIDTH +: DIN_WIDTH]
//   ch_write          per-channel write strobe
//   data_out          folded word
//   data_valid        data_out qualifier
//   sig_out           run signature
//   sig_count         beats counted in the run
//   sig_valid         one-cycle pulse; sig_out and sig_count are final
//   busy              high in RUN and DRAIN
module out_xor_reduce #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DIN_WIDTH = 32,
  parameter int unsigned OUT_WIDTH = 4,
  parameter int unsigned SIG_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        ap_start,
  input  logic                        ap_done,
  input  logic [NUM_CH*DIN_WIDTH-1:0] ch_din,
  input  logic [NUM_CH-1:0]           ch_write,
  output logic [OUT_WIDTH-1:0]        data_out,
  output logic                        data_valid,
  output logic [SIG_WIDTH-1:0]        sig_out,
  output logic [CNT_WIDTH-1:0]        sig_count,
  output logic                        sig_valid,
  output logic                        busy
);

  localparam int unsigned NumChunks = DIN_WIDTH / OUT_WIDTH;

  logic [NUM_CH-1:0][OUT_WIDTH-1:0] fold1_d, fold1_q;
  logic [NUM_CH-1:0]                v1_q;
  logic [OUT_WIDTH-1:0]             xor2_d, xor2_q;
  logic                             v2_q;
  logic [OUT_WIDTH-1:0]             data_out_q;
  logic                             data_valid_q;

  // Stage 1 comb: fold each channel word down to OUT_WIDTH bits.
  always_comb begin
    fold1_d = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      for (int unsigned c = 0; c < NumChunks; c++) begin
        fold1_d[k] = fold1_d[k] ^ ch_din[k*DIN_WIDTH + c*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  // Stage 2 comb: combine only the channels that were written.
  always_comb begin
    xor2_d = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (v1_q[k]) xor2_d = xor2_d ^ fold1_q[k];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      fold1_q      <= '0;
      v1_q         <= '0;
      xor2_q       <= '0;
      v2_q         <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      fold1_q      <= fold1_d;
      v1_q         <= ch_write;
      xor2_q       <= xor2_d;
      v2_q         <= |v1_q;
      data_out_q   <= xor2_q;
      data_valid_q <= v2_q;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

`ifdef OUT_XOR_REDUCE_SIG_EN
  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e               state_q;
  logic [1:0]           drain_q;
  logic                 tag1_q, tag2_q, tag3_q;
  logic [SIG_WIDTH-1:0] sig_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 busy_q;
  logic                 sig_valid_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= StIdle;
      drain_q     <= '0;
      tag1_q      <= 1'b0;
      tag2_q      <= 1'b0;
      tag3_q      <= 1'b0;
      sig_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      sig_valid_q <= 1'b0;
    end else begin
      // Beats are tagged when sampled, so writes in the ap_done cycle still count.
      tag1_q      <= (state_q == StRun) & (|ch_write);
      tag2_q      <= tag1_q;
      tag3_q      <= tag2_q;
      sig_valid_q <= 1'b0;

      if (data_valid_q && tag3_q) begin
        sig_q <= ((sig_q << 1) | (sig_q >> (SIG_WIDTH - 1))) ^ SIG_WIDTH'(data_out_q);
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
      end

      unique case (state_q)
        StIdle: begin
          // ap_done is deliberately ignored here, even alongside ap_start.
          if (ap_start) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
            sig_q   <= '0;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          if (ap_done) begin
            state_q <= StDrain;
            drain_q <= 2'd2;
          end
        end
        StDrain: begin
          // Three cycles let the last tagged beat clear the pipeline.
          if (drain_q == 2'd0) begin
            state_q     <= StDone;
            busy_q      <= 1'b0;
            sig_valid_q <= 1'b1;
          end else begin
            drain_q <= drain_q - 2'd1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sig_out   = sig_q;
  assign sig_count = cnt_q;
  assign sig_valid = sig_valid_q;
  assign busy      = busy_q;
`else
  logic unused_ctrl;
  assign unused_ctrl = ap_start ^ ap_done;

  assign sig_out   = '0;
  assign sig_count = '0;
  assign sig_valid = 1'b0;
  assign busy      = 1'b0;
`endif

endmodule

// File: tb/tb_out_xor_reduce.sv
module tb_out_xor_reduce;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic        ap_done = 1'b0;
  logic [63:0] ch_din = '0;
  logic [1:0]  ch_write = '0;

  logic [3:0]  data_out;
  logic        data_valid;
  logic [15:0] sig_out;
  logic [15:0] sig_count;
  logic        sig_valid;
  logic        busy;

  // Second instance with a 4-bit counter shares all inputs, for the saturation case.
  logic [3:0]  s_data_out;
  logic        s_data_valid;
  logic [15:0] s_sig_out;
  logic [3:0]  s_sig_count;
  logic        s_sig_valid;
  logic        s_busy;

  out_xor_reduce dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .ap_start   (ap_start),
    .ap_done    (ap_done),
    .ch_din     (ch_din),
    .ch_write   (ch_write),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sig_out    (sig_out),
    .sig_count  (sig_count),
    .sig_valid  (sig_valid),
    .busy       (busy)
  );

  out_xor_reduce #(.CNT_WIDTH(4)) dut_sat (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .ap_start   (ap_start),
    .ap_done    (ap_done),
    .ch_din     (ch_din),
    .ch_write   (ch_write),
    .data_out   (s_data_out),
    .data_valid (s_data_valid),
    .sig_out    (s_sig_out),
    .sig_count  (s_sig_count),
    .sig_valid  (s_sig_valid),
    .busy       (s_busy)
  );

  always #5 ap_clk = ~ap_clk;

  int unsigned cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] fold(input logic [31:0] w);
    logic [3:0] r = '0;
    for (int i = 0; i < 8; i++) r = r ^ w[i*4 +: 4];
    return r;
  endfunction

  typedef struct {
    int unsigned due;
    logic [3:0]  data;
    logic        valid;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d0;
    logic [1:0]  wr;
    logic [3:0]  xd;
    logic        xv;
  } vec_t;
  vec_t tbl[8];

  // Drive one cycle of stimulus and queue the folded word expected three edges later.
  task automatic drive(input logic [31:0] d1, input logic [31:0] d0, input logic [1:0] wr,
                       input logic st, input logic dn, input logic [3:0] xd, input logic xv);
    exp_t e;
    @(posedge ap_clk);
    #1;
    ch_din   = {d1, d0};
    ch_write = wr;
    ap_start = st;
    ap_done  = dn;
    e.due    = cyc + 3;
    e.data   = xd;
    e.valid  = xv;
    sb.push_back(e);
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  always @(negedge ap_clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due < cyc) begin
        checks++;
        errors++;
        $display("FAIL sb_overdue: entry due %0d seen at %0d", e.due, cyc);
      end else begin
        check("data_valid", {31'b0, data_valid}, {31'b0, e.valid});
        check("data_out", {28'b0, data_out}, {28'b0, e.data});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation timeout, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] s_model;
    logic        seen;

    // Reset state.
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_data_out", {28'b0, data_out}, 32'h0);
    check("rst_data_valid", {31'b0, data_valid}, 32'h0);
    check("rst_sig_out", {16'b0, sig_out}, 32'h0);
    check("rst_sig_count", {16'b0, sig_count}, 32'h0);
    check("rst_sig_valid", {31'b0, sig_valid}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    ap_rst_n = 1'b1;

    tbl[0] = '{32'h0000_0000, 32'h1234_5678, 2'b01, 4'h8, 1'b1};
    tbl[1] = '{32'h0000_000F, 32'h1234_5678, 2'b11, 4'h7, 1'b1};
    tbl[2] = '{32'h1234_5678, 32'hFFFF_FFFF, 2'b00, 4'h0, 1'b0};
    tbl[3] = '{32'h1234_5678, 32'h0000_0000, 2'b10, 4'h8, 1'b1};
    tbl[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 2'b01, 4'h0, 1'b1};
    tbl[5] = '{32'h0000_0020, 32'h0000_0001, 2'b11, 4'h3, 1'b1};
    tbl[6] = '{32'h1234_5678, 32'hA000_0000, 2'b01, 4'hA, 1'b1};
    tbl[7] = '{32'h0000_000C, 32'hFFFF_FFF0, 2'b10, 4'hC, 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].d1, tbl[i].d0, tbl[i].wr, 1'b0, 1'b0, tbl[i].xd, tbl[i].xv);
    end
    repeat (4) idle();

`ifdef OUT_XOR_REDUCE_SIG_EN
    // Signature run: two beats, then done.
    drive(32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 4'h0, 1'b0);
    @(negedge ap_clk);
    check("busy_before_run", {31'b0, busy}, 32'h0);
    drive(32'h0, 32'h1234_5678, 2'b01, 1'b0, 1'b0, 4'h8, 1'b1);
    @(negedge ap_clk);
    check("busy_run", {31'b0, busy}, 32'h1);
    drive(32'hF, 32'h1234_5678, 2'b11, 1'b0, 1'b0, 4'h7, 1'b1);
    drive(32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      @(negedge ap_clk);
      check("busy_drain", {31'b0, busy}, 32'h1);
      check("sig_valid_drain", {31'b0, sig_valid}, 32'h0);
    end
    idle();
    @(negedge ap_clk);
    check("sig_valid_done", {31'b0, sig_valid}, 32'h1);
    check("busy_done", {31'b0, busy}, 32'h0);
    check("sig_out", {16'b0, sig_out}, 32'h17);
    check("sig_count", {16'b0, sig_count}, 32'h2);
    idle();
    @(negedge ap_clk);
    check("sig_valid_pulse", {31'b0, sig_valid}, 32'h0);
    check("sig_out_hold", {16'b0, sig_out}, 32'h17);
    check("sig_count_hold", {16'b0, sig_count}, 32'h2);

    // Tagging: write in the ap_done cycle counts, the next one does not.
    drive(32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 4'h0, 1'b0);
    drive(32'h0, 32'h0000_000F, 2'b01, 1'b0, 1'b1, 4'hF, 1'b1);
    drive(32'h0, 32'h0000_0003, 2'b01, 1'b0, 1'b0, 4'h3, 1'b1);
    repeat (2) idle();
    idle();
    @(negedge ap_clk);
    check("tag_sig_valid", {31'b0, sig_valid}, 32'h1);
    check("tag_sig_count", {16'b0, sig_count}, 32'h1);
    check("tag_sig_out", {16'b0, sig_out}, 32'hF);
    idle();

    // Saturation: 20 counted beats.
    s_model = '0;
    drive(32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(32'h0, 32'h0000_0001, 2'b01, 1'b0, 1'b0, 4'h1, 1'b1);
      s_model = {s_model[14:0], s_model[15]} ^ 16'h0001;
    end
    drive(32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 4'h0, 1'b0);
    repeat (3) idle();
    idle();
    @(negedge ap_clk);
    check("sat_sig_valid", {31'b0, s_sig_valid}, 32'h1);
    check("sat_sig_count", {28'b0, s_sig_count}, 32'hF);
    check("full_sig_count", {16'b0, sig_count}, 32'd20);
    check("sat_sig_out", {16'b0, sig_out}, {16'b0, s_model});
    idle();

    // Reset mid-run with beats in flight.
    drive(32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(32'h0, 32'h1234_5678, 2'b01, 1'b0, 1'b0, 4'h8, 1'b1);
    end
    #2;
    ap_rst_n = 1'b0;
    ch_write = '0;
    ch_din   = '0;
    sb.delete();
    #1;
    check("mid_rst_data_out", {28'b0, data_out}, 32'h0);
    check("mid_rst_data_valid", {31'b0, data_valid}, 32'h0);
    check("mid_rst_sig_out", {16'b0, sig_out}, 32'h0);
    check("mid_rst_sig_count", {16'b0, sig_count}, 32'h0);
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle();
      @(negedge ap_clk);
      if (sig_valid) seen = 1'b1;
    end
    check("no_sig_valid_after_rst", {31'b0, seen}, 32'h0);
    drive(32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 4'h0, 1'b0);
    drive(32'h0, 32'h1234_5678, 2'b01, 1'b0, 1'b1, 4'h8, 1'b1);
    repeat (3) idle();
    idle();
    @(negedge ap_clk);
    check("post_rst_sig_valid", {31'b0, sig_valid}, 32'h1);
    check("post_rst_sig_out", {16'b0, sig_out}, 32'h8);
    check("post_rst_sig_count", {16'b0, sig_count}, 32'h1);
`else
    // Signature logic absent: its outputs stay 0 whatever the control inputs do.
    drive(32'h0, 32'h1234_5678, 2'b01, 1'b1, 1'b0, 4'h8, 1'b1);
    drive(32'hF, 32'h1234_5678, 2'b11, 1'b0, 1'b1, 4'h7, 1'b1);
    for (int i = 0; i < 6; i++) begin
      idle();
      @(negedge ap_clk);
      check("nosig_sig_out", {16'b0, sig_out}, 32'h0);
      check("nosig_sig_count", {16'b0, sig_count}, 32'h0);
      check("nosig_sig_valid", {31'b0, sig_valid}, 32'h0);
      check("nosig_busy", {31'b0, busy}, 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(32'h0, 32'h1234_5678, 2'b01, 1'b0, 1'b0, 4'h8, 1'b1);
    end
    #2;
    ap_rst_n = 1'b0;
    ch_write = '0;
    ch_din   = '0;
    sb.delete();
    #1;
    check("mid_rst_data_out", {28'b0, data_out}, 32'h0);
    check("mid_rst_data_valid", {31'b0, data_valid}, 32'h0);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    repeat (4) idle();
`endif

    // Let the scoreboard empty, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge ap_clk);
    @(negedge ap_clk);
    check("sb_drained", sb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
